// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction classes, state encoding and IR field positions
package alu_seq_pkg;
  localparam int OP_W = 5;
  localparam int REG_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT = 5'b10001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;
  typedef enum logic [2:0] {CL_ALU3, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT} cls_t;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0 = 4'd1;
  localparam logic [3:0] S_T1 = 4'd2;
  localparam logic [3:0] S_T2 = 4'd3;
  localparam logic [3:0] S_T3 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd5;
  localparam logic [3:0] S_T5 = 4'd6;
  localparam logic [3:0] S_T6 = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;
  localparam int OP_MSB = 31;
  localparam int RA_MSB = 26;
  localparam int RB_MSB = 22;
  localparam int RC_MSB = 18;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: opcode to instruction class and one-hot register selects
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int OPW = 5,
  parameter int NREG = 16
) (
  input  logic [OPW-1:0]   op,
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  input  logic [REG_W-1:0] rc,
  output cls_t             cls,
  output logic [NREG-1:0]  ra_oh,
  output logic [NREG-1:0]  rb_oh,
  output logic [NREG-1:0]  rc_oh
);
  always_comb begin
    cls = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL} ? CL_ALU3 :
          op inside {OP_MUL, OP_DIV} ? CL_MULDIV :
          op inside {OP_NEG, OP_NOT} ? CL_UNARY :
          op == OP_HALT ? CL_HALT : CL_NOP;
  end
  assign ra_oh = NREG'(1) << ra;
  assign rb_oh = NREG'(1) << rb;
  assign rc_oh = NREG'(1) << rc;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired fetch/decode/execute control unit driving the datapath strobes
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPW = 5,
  parameter int NREG = 16,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [31:0]     IR_in,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            PCout,
  output logic            PCin,
  output logic            incPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            read,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            ZLowOut,
  output logic            ZHighOut,
  output logic            HIin,
  output logic            LOin,
  output logic [OPW-1:0]  opcode,
  output logic            done,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);
  logic [3:0] state, state_next;
  cls_t cls;
  logic [NREG-1:0] ra_oh, rb_oh, rc_oh;
  logic [OPW-1:0] op;
  logic alu3, muldiv, unary, t3, t4, t5, t6;
  logic unused_ir;
  assign op = IR_in[OP_MSB -: OPW];
  assign unused_ir = ^IR_in[RC_MSB-REG_W:0];
  alu_seq_decode #(.OPW(OPW), .NREG(NREG)) u_decode (
    .op    (op),
    .ra    (IR_in[RA_MSB -: REG_W]),
    .rb    (IR_in[RB_MSB -: REG_W]),
    .rc    (IR_in[RC_MSB -: REG_W]),
    .cls   (cls),
    .ra_oh (ra_oh),
    .rb_oh (rb_oh),
    .rc_oh (rc_oh)
  );
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (done) instr_count <= instr_count + CNTW'(1);
    end
  end
  // Class is decoded live from IR_in; the IR is stable from T3 until the next fetch
  always_comb begin
    alu3 = cls == CL_ALU3;
    muldiv = cls == CL_MULDIV;
    unary = cls == CL_UNARY;
    t3 = state == S_T3;
    t4 = state == S_T4;
    t5 = state == S_T5;
    t6 = state == S_T6;
    PCout = state == S_T0;
    MARin = PCout;
    incPC = PCout;
    PCin = state == S_T1;
    read = PCin;
    MDRin = PCin;
    MDRout = state == S_T2;
    IRin = MDRout;
    Yin = t3 && (alu3 || muldiv);
    Zin = (t4 && (alu3 || muldiv)) || (t3 && unary);
    opcode = Zin ? op : '0;
    Rout = t3 && muldiv ? ra_oh :
           (t3 && (alu3 || unary)) || (t4 && muldiv) ? rb_oh :
           t4 && alu3 ? rc_oh : '0;
    ZLowOut = (t5 && (alu3 || muldiv)) || (t4 && unary);
    Rin = (t5 && alu3) || (t4 && unary) ? ra_oh : '0;
    LOin = t5 && muldiv;
    ZHighOut = t6 && muldiv;
    HIin = ZHighOut;
    done = (t3 && (cls == CL_NOP || cls == CL_HALT)) || (t4 && unary) || (t5 && alu3) || t6;
    halted = state == S_HALT;
    state_next = state == S_IDLE ? (run ? S_T0 : S_IDLE) :
                 halted || (t3 && cls == CL_HALT) ? S_HALT :
                 done ? (run ? S_T0 : S_IDLE) :
                 state < S_T6 ? state + 4'd1 : S_IDLE;
  end
endmodule
